gpu_draw_engine: RTL and testbench
==================================

// Module: gpu_draw_engine
// PURPOSE
//  Parametrised sprite blitter with its own framebuffer, the successor to the fixed
//  64x32 gpu. Accepts clear/draw commands from the cpu (col=vx, row=vy, height=n_bits,
//  sprite_data) and XORs 8-pixel-wide sprite rows into the framebuffer, one row per
//  clock. Reports collisions on vf and exposes a registered row read port for scanout.
// PARAMETERS
//  WIDTH     64  framebuffer columns; power of two, 8..256
//  HEIGHT    32  framebuffer rows; power of two, 2..256
//  MAX_ROWS  15  max sprite rows; sprite_data width = 8*MAX_ROWS
//  WRAP      0   0 = clip pixels past right/bottom edge; 1 = wrap them around
// PORTS
//  clk          in   1             clock, rising edge
//  rst          in   1             asynchronous reset, active-high
//  clear        in   1             clear command, sampled when idle
//  draw         in   1             draw command, sampled when idle
//  col          in   8             sprite x (vx)
//  row          in   8             sprite y (vy)
//  height       in   4             sprite rows (n_bits)
//  sprite_data  in   8*MAX_ROWS    row i = sprite_data[8*(MAX_ROWS-i)-1 -: 8]
//  rd_row       in   $clog2(HEIGHT) scanout row select
//  rd_data      out  WIDTH         scanout row data; bit WIDTH-1 = column 0
//  busy         out  1             engine in CLEAR or DRAW
//  done         out  1             one-cycle completion pulse
//  vf           out  8             collision flag: 8'h01 or 8'h00
// BEHAVIOUR
//  - Framebuffer: HEIGHT rows of WIDTH bits. Column c maps to bit WIDTH-1-c.
//    Byte MSB is the leftmost pixel.
//  - FSM states: IDLE, CLEAR, DRAW. rst forces CLEAR with row counter 0, so
//    busy=1, done=0, vf=0 and rd_data=0 during reset.
//  - rst asserted mid-operation aborts the operation; no done pulse is issued.
//    After release, the engine re-clears the whole framebuffer.
//  - CLEAR: zeroes one row per cycle for HEIGHT cycles, then goes to IDLE with
//    done=1 for one cycle. vf is unchanged by CLEAR.
//  - IDLE command acceptance: clear and draw arriving together -> clear wins and
//    draw is dropped. Commands that arrive while busy=1 are ignored; they are not queued.
//  - Draw accepted at cycle T latches col mod WIDTH, row mod HEIGHT, the clamped
//    height h = min(height, MAX_ROWS), and sprite_data.
//  - DRAW writes row i at cycle T+1+i, for i = 0..h-1.
//  - Per row: target y = base_row+i. With WRAP=1 use y mod HEIGHT. With WRAP=0
//    and y >= HEIGHT, skip the write and count no collision; the cycle is still used.
//  - Per row: byte placed at columns x..x+7. With WRAP=1 columns >= WIDTH rotate
//    to 0. With WRAP=0 those pixels are discarded.
//  - Per row: new = old ^ mask. Collision if any bit of (old & mask) is set.
//  - Draw end: at cycle T+1+h, done=1 and vf = OR of all row collisions; busy
//    drops that same cycle.
//  - h=0: no writes; done=1 at T+1 with vf=8'h00.
//  - done and busy=0 occur together, so a new command is accepted in the done cycle.
//  - vf holds its value until the next draw completes.
//  - Read port: rd_data <= fb[rd_row] on each clock (1-cycle latency).
//    Read-before-write: a read of a row written in the same cycle returns old data.
// STRUCTURE
//  - gpu_defs.vh holds: state encodings (ST_IDLE/ST_CLEAR/ST_DRAW),
//    SPRITE_W=8, and VF_SET/VF_CLR.
//  - Sub-module gpu_row_blit is combinational. Inputs: old row, byte, x, WRAP.
//    Outputs: new row and collision bit. It holds all shift, rotate and clip logic.
//  - Top holds the FSM, row counter, latched command, framebuffer array and read port.
// TESTING
//  1 Reset, then release -> busy=1 for 32 cycles, done pulse, all 32 rd_data rows = 0.
//  2 draw col=0 row=0 h=1 byte 8'hF0 -> done at T+2, vf=0,
//    row0 = 64'hF000_0000_0000_0000; repeat the same draw -> row0 = 0, vf=8'h01.
//  3 col=60 row=0 byte 8'hFF -> WRAP=0: row0 = 64'h0000_0000_0000_000F;
//    WRAP=1: row0 = 64'hF000_0000_0000_000F.
//  4 row=30 h=4 all bytes 8'h80 col=0 -> WRAP=1: rows 30,31,0,1 bit63 set;
//    WRAP=0: rows 30,31 only; done at T+5 in both cases.
//  5 col=70 row=33 byte 8'h80 -> identical result to col=6 row=1 (row1 bit57);
//    same cycle with clear=1 and draw=1 -> only clear runs.
//  6 rst pulsed during row 2 of an h=5 draw -> no done for the draw, full CLEAR
//    sequence follows, framebuffer all zero.

Source files
------------

// File: rtl/gpu_draw_engine_pkg.sv
// Shared definitions for the sprite draw engine: FSM state encoding, sprite
// geometry and collision flag values, plus a small height clamp helper.
package gpu_draw_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAW  = 2'd2
  } state_e;

  localparam int SPRITE_W = 8;

  localparam logic [7:0] VF_SET = 8'h01;
  localparam logic [7:0] VF_CLR = 8'h00;

  // Limit a requested sprite height to the number of rows the engine holds.
  function automatic logic [3:0] clamp_rows(input logic [3:0] h, input logic [3:0] max_rows);
    logic [3:0] r;
    if (h > max_rows) begin
      r = max_rows;
    end else begin
      r = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpu_draw_engine_row_blit.sv
// gpu_row_blit: combinational XOR of one 8-pixel sprite byte into one
// framebuffer row. Column c is bit WIDTH-1-c; the byte MSB is the leftmost pixel.
// Ports:
//   old_row_i  current row contents
//   byte_i     sprite byte for this row
//   x_i        leftmost column (already reduced mod WIDTH)
//   new_row_o  old_row_i ^ placed mask
//   coll_o     1 when any set sprite pixel lands on a set framebuffer pixel
module gpu_row_blit
  import gpu_draw_engine_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter bit WRAP  = 1'b0
) (
  input  logic [WIDTH-1:0] old_row_i,
  input  logic [7:0]       byte_i,
  input  logic [7:0]       x_i,
  output logic [WIDTH-1:0] new_row_o,
  output logic             coll_o
);

  logic [2*WIDTH-1:0] ext_s;
  logic [2*WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0]   mask_s;

  // The byte sits at the top of a double-width word; shifting right by x puts
  // on-screen pixels in the upper half and the right-edge overflow in the lower
  // half, already aligned to columns 0.. for the wrapped case.
  always_comb begin
    ext_s     = {byte_i, {(2*WIDTH-SPRITE_W){1'b0}}};
    shifted_s = ext_s >> x_i;
    if (WRAP) begin
      mask_s = shifted_s[2*WIDTH-1:WIDTH] | shifted_s[WIDTH-1:0];
    end else begin
      mask_s = shifted_s[2*WIDTH-1:WIDTH];
    end
    new_row_o = old_row_i ^ mask_s;
    coll_o    = |(old_row_i & mask_s);
  end

endmodule

// File: rtl/gpu_draw_engine.sv
// gpu_draw_engine: sprite blitter with a private framebuffer.
// Clears the framebuffer one row per clock and XORs sprite rows into it one
// row per clock, reporting collisions on vf. A registered read port serves scanout.
// Ports:
//   clk, rst            clock; asynchronous active-high reset (forces a full clear)
//   clear, draw         commands, sampled only while idle (clear has priority)
//   col, row, height    sprite position and row count
//   sprite_data         row i at sprite_data[8*(MAX_ROWS-i)-1 -: 8]
//   rd_row / rd_data    scanout row select / row data one clock later
//   busy, done, vf      status: busy, one-cycle completion pulse, collision flag
module gpu_draw_engine
  import gpu_draw_engine_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int HEIGHT   = 32,
  parameter int MAX_ROWS = 15,
  parameter bit WRAP     = 1'b0,
  localparam int YW      = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  draw,
  input  logic [7:0]            col,
  input  logic [7:0]            row,
  input  logic [3:0]            height,
  input  logic [8*MAX_ROWS-1:0] sprite_data,
  input  logic [YW-1:0]         rd_row,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            vf
);

  state_e                state_q, state_d;
  logic [8:0]            cnt_q, cnt_d;
  logic [7:0]            col_q, col_d;
  logic [7:0]            row_q, row_d;
  logic [3:0]            h_q, h_d;
  logic [8*MAX_ROWS-1:0] spr_q, spr_d;
  logic                  coll_q, coll_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            vf_q, vf_d;
  logic [WIDTH-1:0]      rd_data_q;

  logic [WIDTH-1:0] fb_q [HEIGHT];

  logic [8:0]       y_full_s;
  logic             wr_ok_s;
  logic [YW-1:0]    y_idx_s;
  logic [7:0]       cur_byte_s;
  logic [WIDTH-1:0] blit_new_s;
  logic             blit_coll_s;
  logic             coll_now_s;
  logic [3:0]       h_clamp_s;
  logic             fb_we_s;
  logic [YW-1:0]    fb_widx_s;
  logic [WIDTH-1:0] fb_wdata_s;

  // Target row of the current draw step and whether it lands on screen.
  always_comb begin
    y_full_s = {1'b0, row_q} + {5'd0, cnt_q[3:0]};
    y_idx_s  = y_full_s[YW-1:0];
    wr_ok_s  = WRAP || (y_full_s < 9'(HEIGHT));
  end

  // Sprite byte for the current draw step.
  always_comb begin
    cur_byte_s = 8'h00;
    for (int i = 0; i < MAX_ROWS; i++) begin
      if (cnt_q[3:0] == 4'(i)) begin
        cur_byte_s = spr_q[8*(MAX_ROWS-i)-1 -: 8];
      end else begin
        cur_byte_s = cur_byte_s;
      end
    end
  end

  gpu_row_blit #(
    .WIDTH (WIDTH),
    .WRAP  (WRAP)
  ) u_blit (
    .old_row_i (fb_q[y_idx_s]),
    .byte_i    (cur_byte_s),
    .x_i       (col_q),
    .new_row_o (blit_new_s),
    .coll_o    (blit_coll_s)
  );

  // FSM next state, command latch and status outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_d      = col_q;
    row_d      = row_q;
    h_d        = h_q;
    spr_d      = spr_q;
    coll_d     = coll_q;
    vf_d       = vf_q;
    done_d     = 1'b0;
    h_clamp_s  = clamp_rows(height, 4'(MAX_ROWS));
    coll_now_s = coll_q | (wr_ok_s & blit_coll_s);
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = 9'd0;
        end else if (draw) begin
          col_d  = col & 8'(WIDTH-1);
          row_d  = row & 8'(HEIGHT-1);
          h_d    = h_clamp_s;
          spr_d  = sprite_data;
          coll_d = 1'b0;
          cnt_d  = 9'd0;
          if (h_clamp_s == 4'd0) begin
            done_d = 1'b1;
            vf_d   = VF_CLR;
          end else begin
            state_d = ST_DRAW;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == 9'(HEIGHT-1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_DRAW: begin
        if (cnt_q == ({5'd0, h_q} - 9'd1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          vf_d    = coll_now_s ? VF_SET : VF_CLR;
        end else begin
          cnt_d  = cnt_q + 9'd1;
          coll_d = coll_now_s;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = 9'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Framebuffer write port: zero rows while clearing, blit result while drawing.
  always_comb begin
    fb_we_s    = 1'b0;
    fb_widx_s  = y_idx_s;
    fb_wdata_s = blit_new_s;
    if (state_q == ST_CLEAR) begin
      fb_we_s    = 1'b1;
      fb_widx_s  = cnt_q[YW-1:0];
      fb_wdata_s = '0;
    end else if (state_q == ST_DRAW) begin
      fb_we_s = wr_ok_s;
    end else begin
      fb_we_s = 1'b0;
    end
  end

  // Control and status registers; reset lands in CLEAR so the framebuffer is rebuilt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= 9'd0;
      col_q     <= 8'd0;
      row_q     <= 8'd0;
      h_q       <= 4'd0;
      spr_q     <= '0;
      coll_q    <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      vf_q      <= VF_CLR;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      h_q       <= h_d;
      spr_q     <= spr_d;
      coll_q    <= coll_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vf_q      <= vf_d;
      rd_data_q <= fb_q[rd_row];
    end
  end

  // Framebuffer storage; contents are rebuilt by the CLEAR pass after reset.
  always_ff @(posedge clk) begin
    if (fb_we_s) begin
      fb_q[fb_widx_s] <= fb_wdata_s;
    end else begin
      fb_q[fb_widx_s] <= fb_q[fb_widx_s];
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign vf      = vf_q;

endmodule

// File: tb/tb_gpu_draw_engine.sv
module tb_gpu_draw_engine;
  localparam int W  = 64;
  localparam int H  = 32;
  localparam int MR = 15;
  localparam int SW = 8 * MR;

  logic          clk = 1'b0;
  logic          rst, clear, draw;
  logic [7:0]    col, row;
  logic [3:0]    height;
  logic [SW-1:0] sprite_data;
  logic [4:0]    rd_row;
  logic [W-1:0]  rd_data0, rd_data1;
  logic          busy0, busy1, done0, done1;
  logic [7:0]    vf0, vf1;

  gpu_draw_engine #(.WIDTH(W), .HEIGHT(H), .MAX_ROWS(MR), .WRAP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .draw(draw), .col(col), .row(row),
    .height(height), .sprite_data(sprite_data), .rd_row(rd_row),
    .rd_data(rd_data0), .busy(busy0), .done(done0), .vf(vf0));

  gpu_draw_engine #(.WIDTH(W), .HEIGHT(H), .MAX_ROWS(MR), .WRAP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .draw(draw), .col(col), .row(row),
    .height(height), .sprite_data(sprite_data), .rd_row(rd_row),
    .rd_data(rd_data1), .busy(busy1), .done(done1), .vf(vf1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] vf; } done_t;
  typedef struct { int cyc; int r; logic [W-1:0] e0; logic [W-1:0] e1; } rd_t;

  done_t dq0[$];
  done_t dq1[$];
  rd_t   rq[$];

  // Reference model: index 0 clips, index 1 wraps.
  logic [W-1:0] mfb [2][H];
  logic [7:0]   mvf [2];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < 2; k++)
      for (int y = 0; y < H; y++) mfb[k][y] = '0;
  endfunction

  // Pixel-by-pixel sprite XOR straight from the drawing rules.
  function automatic void model_draw(input int k, input int c, input int r, input int h,
                                     input logic [SW-1:0] d);
    bit wrap = (k == 1);
    bit coll = 0;
    int hh = (h > MR) ? MR : h;
    int x0 = c % W;
    int y0 = r % H;
    for (int i = 0; i < hh; i++) begin
      int y = y0 + i;
      logic [7:0] b = d[SW-1-8*i -: 8];
      if (y >= H) begin
        if (!wrap) continue;
        y = y - H;
      end
      for (int p = 0; p < 8; p++) begin
        int x = x0 + p;
        if (!b[7-p]) continue;
        if (x >= W) begin
          if (!wrap) continue;
          x = x - W;
        end
        if (mfb[k][y][W-1-x]) coll = 1;
        mfb[k][y][W-1-x] = ~mfb[k][y][W-1-x];
      end
    end
    mvf[k] = coll ? 8'h01 : 8'h00;
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy0 || busy1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      $display("FAIL busy timeout got=busy want=idle (cycle %0d)", cyc);
    end
  endtask

  // Drive one command at a negedge and post its expected completion.
  task automatic issue(input bit c_en, input bit d_en, input int c, input int r, input int h,
                       input logic [SW-1:0] d);
    int a;
    int hh;
    done_t e;
    clear = c_en; draw = d_en;
    col = c[7:0]; row = r[7:0]; height = h[3:0]; sprite_data = d;
    a  = cyc + 1;
    hh = (h > MR) ? MR : h;
    if (c_en) begin
      model_clear();
      e.cyc = a + H; e.vf = mvf[0]; dq0.push_back(e);
      e.vf = mvf[1]; dq1.push_back(e);
    end else if (d_en) begin
      model_draw(0, c, r, h, d);
      model_draw(1, c, r, h, d);
      e.cyc = a + hh; e.vf = mvf[0]; dq0.push_back(e);
      e.vf = mvf[1]; dq1.push_back(e);
    end
    @(negedge clk);
    clear = 1'b0; draw = 1'b0;
    wait_idle();
  endtask

  task automatic rd_const(input int r, input logic [W-1:0] e0, input logic [W-1:0] e1);
    rd_t t;
    rd_row = r[4:0];
    t.cyc = cyc + 1; t.r = r; t.e0 = e0; t.e1 = e1;
    rq.push_back(t);
    @(negedge clk);
  endtask

  task automatic sweep();
    for (int r = 0; r < H; r++) rd_const(r, mfb[0][r], mfb[1][r]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    done_t e;
    int a;
    rst = 1'b1;
    dq0.delete(); dq1.delete(); rq.delete();
    model_clear();
    mvf[0] = 8'h00; mvf[1] = 8'h00;
    #1;
    chk("reset busy", {busy1, busy0}, 2'b11);
    chk("reset done", {done1, done0}, 2'b00);
    chk("reset vf", {vf1, vf0}, 16'h0000);
    chk("reset rd_data0", rd_data0, 64'd0);
    chk("reset rd_data1", rd_data1, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a = cyc + 1;
    e.cyc = a + H - 1; e.vf = 8'h00;
    dq0.push_back(e); dq1.push_back(e);
    wait_idle();
  endtask

  // Scoreboard monitor: completion pulses and read-port data.
  always @(negedge clk) begin
    done_t e;
    rd_t   t;
    if (done0) begin
      if (dq0.size() == 0) begin
        checks++;
        $display("FAIL done0 unexpected got=1 want=0 (cycle %0d)", cyc);
      end else begin
        e = dq0.pop_front();
        chk("done0 cycle", 64'(cyc), 64'(e.cyc));
        chk("vf0", vf0, e.vf);
      end
    end
    if (done1) begin
      if (dq1.size() == 0) begin
        checks++;
        $display("FAIL done1 unexpected got=1 want=0 (cycle %0d)", cyc);
      end else begin
        e = dq1.pop_front();
        chk("done1 cycle", 64'(cyc), 64'(e.cyc));
        chk("vf1", vf1, e.vf);
      end
    end
    while (rq.size() > 0 && rq[0].cyc <= cyc) begin
      t = rq.pop_front();
      chk($sformatf("rd0 row%0d", t.r), rd_data0, t.e0);
      chk($sformatf("rd1 row%0d", t.r), rd_data1, t.e1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] d;
    rst = 1'b1; clear = 1'b0; draw = 1'b0; col = 8'd0; row = 8'd0; height = 4'd0;
    sprite_data = '0; rd_row = 5'd0;
    model_clear();
    mvf[0] = 8'h00; mvf[1] = 8'h00;
    repeat (2) @(negedge clk);

    // 1: reset and initial clear
    do_reset();
    sweep();

    // 2: draw, then the same draw again erases it with a collision
    d = '0; d[SW-1 -: 8] = 8'hF0;
    issue(0, 1, 0, 0, 1, d);
    rd_const(0, 64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000);
    issue(0, 1, 0, 0, 1, d);
    rd_const(0, 64'd0, 64'd0);
    chk("vf hold", {vf1, vf0}, 16'h0101);

    // 3: right-edge clip vs wrap
    issue(1, 0, 0, 0, 0, '0);
    d = '0; d[SW-1 -: 8] = 8'hFF;
    issue(0, 1, 60, 0, 1, d);
    rd_const(0, 64'h0000_0000_0000_000F, 64'hF000_0000_0000_000F);

    // 4: bottom-edge clip vs wrap
    issue(1, 0, 0, 0, 0, '0);
    d = '0; d[SW-1 -: 32] = 32'h8080_8080;
    issue(0, 1, 0, 30, 4, d);
    rd_const(30, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    rd_const(31, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    rd_const(0, 64'd0, 64'h8000_0000_0000_0000);
    rd_const(1, 64'd0, 64'h8000_0000_0000_0000);

    // 5: coordinates reduce mod size; clear beats draw
    issue(1, 0, 0, 0, 0, '0);
    d = '0; d[SW-1 -: 8] = 8'h80;
    issue(0, 1, 70, 33, 1, d);
    rd_const(1, 64'h0200_0000_0000_0000, 64'h0200_0000_0000_0000);
    issue(1, 0, 0, 0, 0, '0);
    issue(0, 1, 6, 1, 1, d);
    rd_const(1, 64'h0200_0000_0000_0000, 64'h0200_0000_0000_0000);
    issue(1, 1, 0, 0, 1, d);
    sweep();

    // h=0 draw after a collision reports vf=0
    d = '0; d[SW-1 -: 8] = 8'hFF;
    issue(0, 1, 3, 3, 1, d);
    issue(0, 1, 3, 3, 1, d);
    issue(0, 1, 3, 3, 0, d);
    chk("vf after h0", {vf1, vf0}, 16'h0000);

    // command during a clear is ignored
    clear = 1'b1;
    issue(1, 0, 0, 0, 0, '0);
    d = {SW{1'b1}};
    issue(1, 0, 0, 0, 0, '0);
    sweep();
    clear = 1'b1;
    begin
      done_t e;
      e.cyc = cyc + 1 + H; e.vf = mvf[0]; dq0.push_back(e); e.vf = mvf[1]; dq1.push_back(e);
      model_clear();
      @(negedge clk); clear = 1'b0;
      repeat (3) @(negedge clk);
      draw = 1'b1; col = 8'd0; row = 8'd0; height = 4'd2; sprite_data = d;
      @(negedge clk); draw = 1'b0;
      wait_idle();
    end
    sweep();

    // randomized traffic
    for (int it = 0; it < 48; it++) begin
      int op = $urandom_range(0, 11);
      for (int j = 0; j < MR; j++) d[8*j +: 8] = 8'($urandom_range(0, 255));
      if (op == 0) issue(1, 0, 0, 0, 0, '0);
      else if (op == 1) issue(1, 1, $urandom_range(0, 255), $urandom_range(0, 255), 3, d);
      else issue(0, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15), d);
      if (it % 8 == 7) sweep();
    end
    sweep();

    // 6: reset in the middle of an h=5 draw
    draw = 1'b1; col = 8'd0; row = 8'd0; height = 4'd5; sprite_data = {SW{1'b1}};
    @(negedge clk); draw = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    sweep();

    repeat (2) @(negedge clk);
    chk("done0 queue drained", 64'(dq0.size()), 64'd0);
    chk("done1 queue drained", 64'(dq1.size()), 64'd0);
    chk("read queue drained", 64'(rq.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
